// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, 2-entry skid buffer, flush and hold.
// Optional PIPE_STAGE_PERF_EN adds stall/flush event counters.
module pipe_stage_reg #(
    parameter int unsigned       DATA_W    = 64,
    parameter logic [DATA_W-1:0] NOP_VALUE = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic              hold,
    input  logic              flush,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic [1:0]        occupancy
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       flush_cnt
`endif
);

    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              skid_valid_q, skid_valid_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;

    logic acc, eff_ready, xfer, main_load;

    assign in_ready  = ~skid_valid_q;
    assign acc       = in_valid & in_ready & ~flush;
    assign eff_ready = out_ready & ~hold;
    assign xfer      = out_valid_q & eff_ready;
    assign main_load = ~out_valid_q | xfer;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        if (flush) begin
            out_valid_d  = 1'b0;
            out_data_d   = NOP_VALUE;
            skid_valid_d = 1'b0;
        end else if (main_load) begin
            // skid entry is older than any new input, so it always wins
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_data_d   = skid_data_q;
                skid_valid_d = 1'b0;
            end else if (acc) begin
                out_valid_d = 1'b1;
                out_data_d  = in_data;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (acc) begin
            skid_valid_d = 1'b1;
            skid_data_d  = in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= NOP_VALUE;
            skid_valid_q <= 1'b0;
            skid_data_q  <= NOP_VALUE;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign occupancy = {1'b0, out_valid_q} + {1'b0, skid_valid_q};

`ifdef PIPE_STAGE_PERF_EN
    logic [31:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (out_valid_q & ~eff_ready) stall_cnt_q <= stall_cnt_q + 32'd1;
            if (flush)                    flush_cnt_q <= flush_cnt_q + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed and scoreboard checks for pipe_stage_reg at DATA_W=17.
module tb_pipe_stage_reg;

    localparam int unsigned W = 17;

    logic         clk;
    logic         reset;
    logic         in_valid;
    logic [W-1:0] in_data;
    logic         in_ready;
    logic         hold;
    logic         flush;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic         out_ready;
    logic [1:0]   occupancy;
`ifdef PIPE_STAGE_PERF_EN
    logic [31:0]  stall_cnt;
    logic [31:0]  flush_cnt;
`endif

    int errors = 0;
    int checks = 0;

    pipe_stage_reg #(.DATA_W(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .hold      (hold),
        .flush     (flush),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .occupancy (occupancy)
`ifdef PIPE_STAGE_PERF_EN
        ,
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; in_data = '0; hold = 1'b0;
        flush = 1'b0; out_ready = 1'b0;
        step(); step();
        reset = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (out_data !== 17'h0) begin errors++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
        checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL reset_occupancy got=%0d exp=0", occupancy); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_stream();
        logic [W-1:0] exp;
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            exp = W'(i);
            in_valid = 1'b1; in_data = exp;
            step();
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp || occupancy !== 2'd1)
                begin errors++; $display("FAIL stream_%0d got v=%b d=%h occ=%0d exp v=1 d=%h occ=1", i, out_valid, out_data, occupancy, exp); end
        end
        in_valid = 1'b0;
        step();
        checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0)
            begin errors++; $display("FAIL stream_drain got v=%b occ=%0d exp v=0 occ=0", out_valid, occupancy); end
    endtask

    task automatic test_hold();
        out_ready = 1'b1; hold = 1'b0;
        in_valid = 1'b1; in_data = 17'hA1;
        step();
        checks++; if (out_data !== 17'hA1 || occupancy !== 2'd1)
            begin errors++; $display("FAIL hold_load got d=%h occ=%0d exp d=a1 occ=1", out_data, occupancy); end
        hold = 1'b1; in_data = 17'hA2;
        step();
        checks++; if (out_valid !== 1'b1 || out_data !== 17'hA1 || in_ready !== 1'b0 || occupancy !== 2'd2)
            begin errors++; $display("FAIL hold_skid got v=%b d=%h rdy=%b occ=%0d exp v=1 d=a1 rdy=0 occ=2", out_valid, out_data, in_ready, occupancy); end
        in_data = 17'hA3;
        step();
        checks++; if (out_data !== 17'hA1 || occupancy !== 2'd2)
            begin errors++; $display("FAIL hold_full got d=%h occ=%0d exp d=a1 occ=2", out_data, occupancy); end
        hold = 1'b0;
        step();
        checks++; if (out_data !== 17'hA2 || occupancy !== 2'd1 || in_ready !== 1'b1)
            begin errors++; $display("FAIL hold_release got d=%h occ=%0d rdy=%b exp d=a2 occ=1 rdy=1", out_data, occupancy, in_ready); end
        step();
        checks++; if (out_valid !== 1'b1 || out_data !== 17'hA3 || occupancy !== 2'd1)
            begin errors++; $display("FAIL hold_a3 got v=%b d=%h occ=%0d exp v=1 d=a3 occ=1", out_valid, out_data, occupancy); end
        in_valid = 1'b0;
        step();
        checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0)
            begin errors++; $display("FAIL hold_drain got v=%b occ=%0d exp v=0 occ=0", out_valid, occupancy); end
    endtask

    task automatic test_flush();
        out_ready = 1'b1; hold = 1'b1;
        in_valid = 1'b1; in_data = 17'hC1;
        step();
        in_data = 17'hC2;
        step();
        checks++; if (occupancy !== 2'd2)
            begin errors++; $display("FAIL flush_fill got occ=%0d exp occ=2", occupancy); end
        in_data = 17'hB0; flush = 1'b1;
        step();
        checks++; if (out_valid !== 1'b0 || out_data !== 17'h0 || occupancy !== 2'd0 || in_ready !== 1'b1)
            begin errors++; $display("FAIL flush_state got v=%b d=%h occ=%0d rdy=%b exp v=0 d=0 occ=0 rdy=1", out_valid, out_data, occupancy, in_ready); end
        flush = 1'b0; in_valid = 1'b0; hold = 1'b0;
        step();
        checks++; if (out_valid !== 1'b0 || out_data !== 17'h0)
            begin errors++; $display("FAIL flush_no_b0 got v=%b d=%h exp v=0 d=0", out_valid, out_data); end
    endtask

    task automatic test_random();
        logic [W-1:0] q[$];
        logic [W-1:0] exp;
        logic         acc_now, xfer_now;
        int           bad = 0;
        hold = 1'b0; flush = 1'b0; in_valid = 1'b0;
        for (int c = 0; c < 10000; c++) begin
            if (!in_valid && ($urandom % 2) == 0) begin
                in_valid = 1'b1;
                in_data  = W'($urandom);
            end
            out_ready = ($urandom % 2) == 0;
            #1;
            acc_now  = in_valid & in_ready;
            xfer_now = out_valid & out_ready;
            if (xfer_now) begin
                exp = (q.size() > 0) ? q.pop_front() : ~out_data;
                checks++; if (out_data !== exp && bad < 20)
                    begin errors++; bad++; $display("FAIL rand_data cyc=%0d got=%h exp=%h", c, out_data, exp); end
                else if (out_data !== exp) errors++;
            end
            if (acc_now) q.push_back(in_data);
            step();
            if (acc_now) in_valid = 1'b0;
            checks++; if (occupancy !== 2'(q.size()) && bad < 20)
                begin errors++; bad++; $display("FAIL rand_occ cyc=%0d got=%0d exp=%0d", c, occupancy, q.size()); end
            else if (occupancy !== 2'(q.size())) errors++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            if (out_valid) begin
                exp = (q.size() > 0) ? q.pop_front() : ~out_data;
                checks++; if (out_data !== exp)
                    begin errors++; $display("FAIL rand_drain got=%h exp=%h", out_data, exp); end
            end
            step();
        end
        checks++; if (q.size() != 0 || out_valid !== 1'b0)
            begin errors++; $display("FAIL rand_leftover got q=%0d v=%b exp q=0 v=0", q.size(), out_valid); end
    endtask

`ifdef PIPE_STAGE_PERF_EN
    task automatic test_perf();
        reset = 1'b1; in_valid = 1'b0; hold = 1'b0; flush = 1'b0; out_ready = 1'b0;
        step();
        reset = 1'b0;
        checks++; if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0)
            begin errors++; $display("FAIL perf_reset got s=%0d f=%0d exp 0 0", stall_cnt, flush_cnt); end
        in_valid = 1'b1; in_data = 17'h55;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) step();
        out_ready = 1'b1; flush = 1'b1;
        step(); step();
        flush = 1'b0;
        checks++; if (stall_cnt !== 32'd5 || flush_cnt !== 32'd2)
            begin errors++; $display("FAIL perf_counts got s=%0d f=%0d exp s=5 f=2", stall_cnt, flush_cnt); end
    endtask
`endif

    initial begin
        test_reset();
        test_stream();
        test_hold();
        test_flush();
        test_random();
`ifdef PIPE_STAGE_PERF_EN
        test_perf();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Parametrised pipeline stage register with a full valid/ready handshake, a 2-entry skid buffer, synchronous flush and stall hold. Generalises the fixed 32-bit PC/instruction latch to an arbitrary payload width. Sustains one transfer per cycle with a registered in_ready. Drops between any two pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB) of the multi-cycle/pipelined core.

Parameters:
DATA_W, 64, payload width in bits (e.g. {pc, instruction}); must be >= 1
NOP_VALUE, {DATA_W{1'b0}}, value loaded into out_data on reset and flush (bubble encoding)

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous active-high reset
in_valid  input  1  upstream offers in_data this cycle
in_data  input  DATA_W  upstream payload
in_ready  output  1  stage can accept; registered, equals NOT skid_valid
hold  input  1  stall request; while 1, stage behaves as if out_ready=0
flush  input  1  squash all held entries and any input this cycle
out_valid  output  1  out_data is a valid entry
out_data  output  DATA_W  payload at head of stage
out_ready  input  1  downstream accepts out_data this cycle
occupancy  output  2  number of held entries, 0..2

Behaviour:
- Clock/reset: one clock, clk; reset synchronous, active-high. Reset has priority over every other input.
- Reset values: out_valid=0, out_data=NOP_VALUE, skid_valid=0, occupancy=0. in_ready=1 from the first cycle after the reset edge.
- Definitions:
  - acc = in_valid & in_ready & ~flush
  - eff_ready = out_ready & ~hold
  - xfer = out_valid & eff_ready
- Main register (out_*): loads when ~out_valid | xfer.
  - Loads skid contents if skid_valid, else in_data if acc.
  - If neither is available and xfer occurs, out_valid goes to 0 and out_data holds its value.
- Skid register: captures in_data when acc & out_valid & ~xfer. Clears when its contents move to main.
- Order is strict FIFO; the skid entry always precedes the new input.
- Latency: input accepted at edge N is visible on out_* after edge N when main is empty or transferring. Otherwise it is visible one edge after the skid drains.
- Throughput: 1 entry per cycle with in_valid=1 and eff_ready=1 continuously.
- Full (occupancy=2): in_ready=0. in_valid is ignored with no data corruption.
- Empty (occupancy=0): out_valid=0.
- Simultaneous acc and xfer with occupancy=1: the new entry goes directly to main. occupancy stays 1.
- Simultaneous acc and xfer with occupancy=2: skid moves to main and input is not accepted (in_ready=0). occupancy becomes 1.
- flush: at the next edge, out_valid=0, skid_valid=0, out_data=NOP_VALUE, occupancy=0. Input that cycle is discarded. A flush with hold=1 still flushes.
- hold=1 with out_valid=1: out_valid and out_data are stable. The stage still accepts into skid while in_ready=1.
- Upstream must keep in_valid/in_data stable until accepted. Downstream may change out_ready freely.
- Reset mid-operation: all entries are lost and the state equals the reset values.
- occupancy = out_valid + skid_valid, computed from registers.

Optional Feature:
PIPE_STAGE_PERF_EN
- Defined: adds outputs stall_cnt[31:0] and flush_cnt[31:0].
  - stall_cnt increments each cycle with out_valid & ~eff_ready.
  - flush_cnt increments on each cycle with flush=1.
  - Both wrap from 0xFFFFFFFF to 0, clear on reset, and do not count during reset.
- Undefined: no counter ports and no counter logic. Datapath behaviour is identical in both builds.

Test Plan:
- Reset held 2 cycles, then released -> out_valid=0, out_data=0, occupancy=0, in_ready=1.
- Stream 0x...01 to 0x...08 with in_valid=1 and out_ready=1 -> out_data shows 01..08 on consecutive cycles, 1-cycle latency, no bubbles.
- Stream 0xA1,0xA2,0xA3, hold=1 from the cycle after 0xA1 is accepted -> 0xA1 stays on out_data, 0xA2 goes into skid, in_ready=0, occupancy=2. Release hold -> outputs in order 0xA1, 0xA2, 0xA3, none lost or duplicated.
- occupancy=2 with in_valid=1 (0xB0) and flush=1 -> next cycle out_valid=0, out_data=NOP_VALUE, occupancy=0, in_ready=1. 0xB0 never appears.
- Random in_valid/out_ready at 50% each for 10k cycles with DATA_W=17 -> output sequence equals input sequence per scoreboard; occupancy never exceeds 2.
- PIPE_STAGE_PERF_EN build: 5 cycles with out_valid=1 and out_ready=0, then 2 flush cycles -> stall_cnt=5, flush_cnt=2.
